operand_fetch: RTL
==================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning register/data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 8, meaning number of general-purpose registers; address width is log2(NREGS).
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port rst_b, input, 1, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port wr_en, input, 1, register write strobe.
REQ-006 The block SHALL have port wr_addr, input, log2(NREGS), destination register of the write.
REQ-007 The block SHALL have port wr_data, input, WIDTH, write data.
REQ-008 The block SHALL have port req_valid, input, 1, operand-read request present.
REQ-009 The block SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-010 The block SHALL have port rs1, input, log2(NREGS), source register for operand A.
REQ-011 The block SHALL have port rs2, input, log2(NREGS), source register for operand B.
REQ-012 The block SHALL have port rsp_valid, output, 1, operands on op_a/op_b are valid.
REQ-013 The block SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-014 The block SHALL have port op_a, output, WIDTH, operand A value.
REQ-015 The block SHALL have port op_b, output, WIDTH, operand B value.

Function
REQ-016 Writes SHALL update register wr_addr with wr_data at the rising edge where wr_en=1, independent of the read handshake.
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-018 The response SHALL have 1-cycle latency: operands captured at the accept edge, rsp_valid=1 from the following cycle.
REQ-019 Write-through bypass: if wr_en=1 and wr_addr equals rs1 (rs2) at the accept edge, op_a (op_b) SHALL capture wr_data, not the old register value.
REQ-020 If rs1 equals rs2, op_a and op_b SHALL be identical, including under bypass.
REQ-021 The response SHALL be a snapshot: while rsp_valid=1 and rsp_ready=0, op_a/op_b SHALL hold, even if a later write targets the captured registers.
REQ-022 The FSM SHALL have states EMPTY (no response held) and FULL (response held).
REQ-023 In EMPTY, req_ready SHALL be 1; an accepted request moves to FULL.
REQ-024 In FULL, req_ready SHALL equal rsp_ready, allowing back-to-back throughput of one request per cycle.
REQ-025 In FULL with rsp_ready=1 and a new accepted request, the block SHALL stay FULL and load the new operands at that edge.
REQ-026 In FULL with rsp_ready=1 and no request accepted, the block SHALL go to EMPTY.
REQ-027 In FULL with rsp_ready=0, state and operands SHALL hold and no request SHALL be accepted.
REQ-028 req_ready SHALL be a function of state and rsp_ready only, never of req_valid.
REQ-029 In EMPTY, op_a/op_b SHALL hold their last value; consumers SHALL ignore them when rsp_valid=0.

Reset
REQ-030 While rst_b=0, the block SHALL immediately, without a clock, set all registers to 0, state to EMPTY, rsp_valid=0, op_a=0 and op_b=0.
REQ-031 Reset asserted while in FULL SHALL discard the held response; no response SHALL appear after release.
REQ-032 After rst_b release, req_ready SHALL be 1 in the first cycle.

Structure
REQ-033 WIDTH, NREGS, the address-width constant and the EMPTY/FULL state encoding SHALL live in the shared processor package.
REQ-034 Each storage register SHALL be an instance of one sub-module, reg16_en: a WIDTH-bit enable register with clk/rst_b, no bypass output; bypass logic SHALL reside in operand_fetch.

Verification
REQ-035 Scenario 1, write then read: write R3=0x1234, then request rs1=3, rs2=0 -> next cycle rsp_valid=1, op_a=0x1234, op_b=0x0000.
REQ-036 Scenario 2, bypass: same edge wr_en=1, wr_addr=5, wr_data=0xBEEF with request rs1=5, rs2=5 -> op_a=op_b=0xBEEF.
REQ-037 Scenario 3, snapshot under stall: response op_a=0x0011 from R1, rsp_ready=0 for 3 cycles while R1 is written 0x2222 -> op_a stays 0x0011 and req_ready=0 for those cycles.
REQ-038 Scenario 4, throughput: continuous req_valid=1 and rsp_ready=1 over rs1=0..7 -> 8 responses on 8 consecutive cycles, in order.
REQ-039 Scenario 5, reset mid-operation: assert rst_b=0 while in FULL holding 0xAAAA -> rsp_valid=0 and op_a=0 immediately, without a clock; after release, reading any register returns 0.
REQ-040 Scenario 6, drain: one request, then req_valid=0 with rsp_ready=1 -> rsp_valid is 1 for exactly one cycle, then state returns to EMPTY.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared sizing constants and response-buffer state encoding
package operand_fetch_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 8;
    localparam int DEF_AW    = $clog2(DEF_NREGS);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/reg16_en.sv
// reg16_en: WIDTH-bit enable register with asynchronous active-low clear
module reg16_en #(
    parameter int WIDTH = operand_fetch_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register file with write-through bypass and a one-entry
// snapshot response buffer (EMPTY/FULL) for operand reads
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b
);
    logic [WIDTH-1:0] rf [NREGS];
    logic [WIDTH-1:0] op_a_q, op_b_q, op_a_d, op_b_d;
    state_t           state_q, state_d;
    logic             accept;

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        reg16_en #(.WIDTH(WIDTH)) u_reg (
            .clk  (clk),
            .rst_b(rst_b),
            .en   (wr_en && wr_addr == AW'(g)),
            .d    (wr_data),
            .q    (rf[g])
        );
    end

    // Same-edge writes are forwarded so a read never sees stale data.
    always_comb begin
        req_ready = (state_q == EMPTY) ? 1'b1 : rsp_ready;
        accept    = req_valid && req_ready;
        op_a_d    = (wr_en && wr_addr == rs1) ? wr_data : rf[rs1];
        op_b_d    = (wr_en && wr_addr == rs2) ? wr_data : rf[rs2];
        state_d   = accept ? FULL : (rsp_ready ? EMPTY : state_q);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= EMPTY;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q <= op_a_d;
                op_b_q <= op_b_d;
            end
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
endmodule
